fifo_wptr_full: RTL and testbench

- Write-side control stage of the dual-clock FIFO, running entirely in the wclk domain.
- Turns producer write requests into memory write strobes and addresses (waddr, wen) for the FIFO storage array.
- Keeps the binary and Gray write pointers and brings the read-side Gray pointer across with a 2-flop synchronizer.
- Produces registered full, almost-full, free-space and sticky overflow status for the producer.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/fifo_sync_r2w.sv | 25 ++
 rtl/fifo_wptr_full.sv | 79 +++++++
 tb/tb_fifo_wptr_full.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the dual-clock FIFO: depth/width derivation and
// Gray/binary conversion used by both the write-side and read-side stages.
package fifo_pkg;

    localparam int MAX_PTR_W = 32;
    typedef logic [MAX_PTR_W-1:0] ptr_word_t;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Operands are zero-extended pointers of any width up to MAX_PTR_W;
    // callers cast the result back down to their own pointer width.
    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = g;
        for (int i = 1; i < MAX_PTR_W; i++) begin
            b ^= g >> i;
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync_r2w.sv
// Two-flop synchronizer bringing the read-domain Gray pointer into wclk.
module fifo_sync_r2w #(
    parameter int WIDTH = 4
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic [WIDTH-1:0] rptr,
    output logic [WIDTH-1:0] rq2
);

    logic [WIDTH-1:0] rq1;

    // NOTE: sequential state uses non-blocking assignments so rq2 takes the
    // old rq1, giving two real register stages instead of one.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= rptr;
            rq2 <= rq1;
        end
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side control of the dual-clock FIFO: write pointers, storage strobe
// and registered full / almost-full / free-space / sticky overflow status.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 1
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wen,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wfree,
    output logic                  woverflow
);

    localparam int PW    = ptr_width(ADDR_WIDTH);
    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rq2;
    logic [PW-1:0] rbin;
    logic [PW-1:0] used;
    logic [PW-1:0] free_next;
    logic          full_next;
    logic          af_next;

    fifo_sync_r2w #(.WIDTH(PW)) u_sync (
        .wclk (wclk),
        .wrst (wrst),
        .rptr (rptr),
        .rq2  (rq2)
    );

    assign wen   = winc & ~wfull;
    assign waddr = wbin[ADDR_WIDTH-1:0];

    // NOTE: every signal in this block is fully assigned on every pass, so no
    // latch can be inferred.
    always_comb begin
        wbin_next  = wbin + PW'(wen);
        wgray_next = PW'(bin2gray(ptr_word_t'(wbin_next)));
        rbin       = PW'(gray2bin(ptr_word_t'(rq2)));
        used       = wbin_next - rbin;
        free_next  = PW'(DEPTH) - used;
        // Full when the pointers match except for the wrap bit, seen in Gray
        // as the two top bits inverted.
        full_next  = (wgray_next == {~rq2[ADDR_WIDTH:ADDR_WIDTH-1], rq2[ADDR_WIDTH-2:0]});
        af_next    = (free_next <= PW'(AF_THRESH));
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= (DEPTH <= AF_THRESH);
            wfree        <= PW'(DEPTH);
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= full_next;
            walmost_full <= af_next;
            wfree        <= free_next;
            if (winc && wfull) begin
                woverflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full: a cycle model predicts each post-edge
// output set, queued when stimulus is driven and compared after the edge.
module tb_fifo_wptr_full;

    localparam int AW    = 3;
    localparam int AF    = 1;
    localparam int DEPTH = 8;

    logic          wclk = 1'b0;
    logic          wrst = 1'b1;
    logic          winc = 1'b0;
    logic [AW:0]   rptr = '0;
    logic [AW-1:0] waddr;
    logic          wen;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          walmost_full;
    logic [AW:0]   wfree;
    logic          woverflow;

    fifo_wptr_full #(.ADDR_WIDTH(AW), .AF_THRESH(AF)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .rptr         (rptr),
        .waddr        (waddr),
        .wen          (wen),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wfree        (wfree),
        .woverflow    (woverflow)
    );

    always #5 wclk = ~wclk;

    typedef struct packed {
        logic [AW-1:0] waddr;
        logic [AW:0]   wptr;
        logic          wfull;
        logic          waf;
        logic [AW:0]   wfree;
        logic          wovf;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [AW:0] m_bin  = '0;
    logic [AW:0] m_q1   = '0;
    logic [AW:0] m_q2   = '0;
    logic        m_full = 1'b0;
    logic        m_af   = 1'b0;
    logic [AW:0] m_free = 4'd8;
    logic        m_ovf  = 1'b0;

    function automatic logic [AW:0] to_gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] from_gray(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, then compare.
    task automatic cycle(input logic r, input logic w, input logic [AW:0] rp);
        logic        acc;
        logic [AW:0] nb;
        logic [AW:0] used;
        exp_t        e;
        exp_t        got;
        wrst = r;
        winc = w;
        rptr = rp;
        #1;
        if (!r) check("wen", wen, w & ~m_full);
        if (r) begin
            m_bin = '0; m_q1 = '0; m_q2 = '0;
            m_full = 1'b0; m_af = 1'b0; m_free = 4'(DEPTH); m_ovf = 1'b0;
        end else begin
            acc = w & ~m_full;
            if (w && m_full) m_ovf = 1'b1;
            nb     = m_bin + {3'b000, acc};
            used   = nb - from_gray(m_q2);
            m_free = 4'(DEPTH) - used;
            m_full = (used == 4'(DEPTH));
            m_af   = (m_free <= 4'(AF));
            m_bin  = nb;
            m_q2   = m_q1;
            m_q1   = rp;
        end
        e.waddr = m_bin[AW-1:0];
        e.wptr  = to_gray(m_bin);
        e.wfull = m_full;
        e.waf   = m_af;
        e.wfree = m_free;
        e.wovf  = m_ovf;
        exp_q.push_back(e);
        @(posedge wclk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            got = exp_q.pop_front();
            check("waddr", waddr, got.waddr);
            check("wptr", wptr, got.wptr);
            check("wfull", wfull, got.wfull);
            check("walmost_full", walmost_full, got.waf);
            check("wfree", wfree, got.wfree);
            check("woverflow", woverflow, got.wovf);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [AW:0] gray_seq [8];
        logic [AW:0] prev_wptr;
        logic [AW-1:0] prev_waddr;
        logic seen_wrap;
        gray_seq = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};

        // Reset held for two edges, then released
        cycle(1'b1, 1'b0, 4'd0);
        cycle(1'b1, 1'b0, 4'd0);
        check("rst_waddr", waddr, 0);
        check("rst_wptr", wptr, 4'b0000);
        check("rst_wfull", wfull, 0);
        check("rst_wfree", wfree, 8);
        check("rst_waf", walmost_full, 0);
        check("rst_wovf", woverflow, 0);

        // Fill with the reader parked at zero
        for (int i = 0; i < 8; i++) begin
            check("fill_waddr_pre", waddr, i);
            cycle(1'b0, 1'b1, 4'd0);
            check("fill_wptr", wptr, gray_seq[i]);
            if (i == 6) begin
                check("fill7_wfree", wfree, 1);
                check("fill7_waf", walmost_full, 1);
                check("fill7_wfull", wfull, 0);
            end
        end
        check("fill8_wfull", wfull, 1);
        check("fill8_wfree", wfree, 0);

        // Write attempt while full
        cycle(1'b0, 1'b1, 4'd0);
        check("ovf_wptr", wptr, 4'b1100);
        check("ovf_flag", woverflow, 1);
        cycle(1'b0, 1'b0, 4'd0);
        check("ovf_sticky", woverflow, 1);

        // Reader advances to binary 2; visible on the third edge
        cycle(1'b0, 1'b0, 4'b0011);
        check("drain_e1_wfull", wfull, 1);
        cycle(1'b0, 1'b0, 4'b0011);
        check("drain_e2_wfull", wfull, 1);
        cycle(1'b0, 1'b0, 4'b0011);
        check("drain_e3_wfull", wfull, 0);
        check("drain_e3_wfree", wfree, 2);

        // Reader catches up one step at a time
        for (int k = 3; k <= 8; k++) cycle(1'b0, 1'b0, to_gray(4'(k)));
        cycle(1'b0, 1'b0, to_gray(4'd8));
        cycle(1'b0, 1'b0, to_gray(4'd8));
        check("caught_up_wfree", wfree, 8);

        // Twenty writes with the reader trailing closely, across the wrap
        seen_wrap = 1'b0;
        for (int i = 0; i < 20; i++) begin
            prev_wptr  = wptr;
            prev_waddr = waddr;
            cycle(1'b0, 1'b1, to_gray(m_bin));
            check("wrap_no_full", wfull, 0);
            if (prev_wptr == 4'b1000 && wptr == 4'b0000 && prev_waddr == 3'd7 && waddr == 3'd0)
                seen_wrap = 1'b1;
        end
        check("wrap_seen", seen_wrap, 1);
        check("wrap_wptr_end", wptr, 4'b1010);

        // Reset in the middle of a fill, with a write requested alongside it
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, to_gray(m_bin));
        check("midfill_wovf_before", woverflow, 1);
        cycle(1'b1, 1'b1, 4'd0);
        check("midrst_waddr", waddr, 0);
        check("midrst_wptr", wptr, 0);
        check("midrst_wfree", wfree, 8);
        check("midrst_wovf", woverflow, 0);
        cycle(1'b0, 1'b1, 4'd0);
        check("post_rst_wptr", wptr, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
